// File: rtl/dfg_loop_settle_if.sv
// rtl/dfg_loop_settle_if.sv - sample-in / result-out handshake bundle for dfg_loop_settle
interface dfg_loop_settle_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_converged;
    logic [CNT_W-1:0] out_iters;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_converged, out_iters
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_converged, out_iters
    );
endinterface

// File: rtl/dfg_loop_settle.sv
// rtl/dfg_loop_settle.sv - register-broken ring evaluator iterating to a fixed point or cap
module dfg_loop_settle #(
    parameter int WIDTH    = 8,
    parameter int MAX_ITER = 16,
    parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
    input logic              clk,
    input logic              rst,
    dfg_loop_settle_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d, w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_conv_q, out_conv_d;
    logic [CNT_W-1:0] out_iters_q, out_iters_d;

    logic [WIDTH-1:0] d_val, a_n, b_n, x_n, y_n, z_n, w_n;
    logic [CNT_W-1:0] cnt_n;
    logic             stable;

    always_comb begin
        // One evaluation step, every ring value taken from the previous step
        d_val  = i_q + WIDTH'(2);
        a_n    = b_q + d_val;
        b_n    = a_q + WIDTH'(1);
        x_n    = y_q ^ i_q;
        y_n    = x_q;
        w_n    = y_q & z_q;
        z_n    = w_q;
        cnt_n  = cnt_q + CNT_W'(1);
        stable = ({x_n, y_n, z_n, w_n} == {x_q, y_q, z_q, w_q});

        state_d     = state_q;
        i_d         = i_q;
        a_d         = a_q;
        b_d         = b_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        w_d         = w_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_conv_d  = out_conv_q;
        out_iters_d = out_iters_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    i_d     = bus.in_data;
                    a_d     = '0;
                    b_d     = '0;
                    x_d     = '0;
                    y_d     = '0;
                    z_d     = '0;
                    w_d     = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                a_d   = a_n;
                b_d   = b_n;
                x_d   = x_n;
                y_d   = y_n;
                z_d   = z_n;
                w_d   = w_n;
                cnt_d = cnt_n;
                // The a/b accumulator never gates termination; only the logic ring does
                if (stable || (cnt_n == MAX_CNT)) begin
                    out_data_d  = b_n | x_n;
                    out_conv_d  = stable;
                    out_iters_d = cnt_n;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            w_q         <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_conv_q  <= 1'b0;
            out_iters_q <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            a_q         <= a_d;
            b_q         <= b_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            w_q         <= w_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_conv_q  <= out_conv_d;
            out_iters_q <= out_iters_d;
        end
    end

    assign bus.in_ready      = (state_q == S_IDLE);
    assign bus.out_valid     = (state_q == S_DONE);
    assign bus.out_data      = out_data_q;
    assign bus.out_converged = out_conv_q;
    assign bus.out_iters     = out_iters_q;
endmodule

// File: tb/tb_dfg_loop_settle.sv
// tb/tb_dfg_loop_settle.sv - scoreboard bench for dfg_loop_settle (MAX_ITER=16 and MAX_ITER=1)
module tb_dfg_loop_settle;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dfg_loop_settle_if #(.WIDTH(8), .CNT_W(5)) bus  ();
    dfg_loop_settle_if #(.WIDTH(8), .CNT_W(1)) bus1 ();

    dfg_loop_settle #(.WIDTH(8), .MAX_ITER(16), .CNT_W(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dfg_loop_settle #(.WIDTH(8), .MAX_ITER(1), .CNT_W(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        logic [7:0] data;
        logic       conv;
        logic [4:0] iters;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_results = 0;
    bit   seen = 1'b0;
    int   first_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every cycle a result is presented it must match the oldest expected entry
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                if (!seen) begin
                    seen      = 1'b1;
                    first_cyc = cyc;
                    check("latency", first_cyc - sb[0].acc, 32'(sb[0].iters));
                end
                check("out_data", bus.out_data, sb[0].data);
                check("out_converged", bus.out_converged, sb[0].conv);
                check("out_iters", bus.out_iters, sb[0].iters);
                check("in_ready_busy", bus.in_ready, 32'd0);
                if (bus.out_ready) begin
                    void'(sb.pop_front());
                    n_results++;
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] din, input bit push,
                        input logic [7:0] edata, input logic econv, input logic [4:0] eiters);
        exp_t e;
        bit   ok;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = din;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("send_timeout", 32'd0, 32'd1);
        end else if (push) begin
            e.data  = edata;
            e.conv  = econv;
            e.iters = eiters;
            e.acc   = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int  vcnt;
        int  acc1;
        bit  ok;

        rst = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 32'd1);
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_converged", bus.out_converged, 32'd0);
        check("rst_out_iters", bus.out_iters, 32'd0);
        check("rst1_in_ready", bus1.in_ready, 32'd1);

        // Immediate convergence, then the non-converging period-4 ring
        bus.out_ready = 1'b1;
        send(8'h00, 1'b1, 8'h01, 1'b1, 5'd1);
        drain();
        send(8'h01, 1'b1, 8'h20, 1'b0, 5'd16);
        drain();

        // Stall the consumer and poke in_valid while the result is held
        bus.out_ready = 1'b0;
        send(8'h01, 1'b1, 8'h20, 1'b0, 5'd16);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("stall_wait_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_held_valid", bus.out_valid, 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        // Reset two cycles into ITER discards the sample
        send(8'h01, 1'b0, 8'h00, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 32'd1);
        check("midrst_out_valid", bus.out_valid, 32'd0);
        vcnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.out_valid) vcnt++;
        end
        check("midrst_no_result", vcnt, 32'd0);
        send(8'h00, 1'b1, 8'h01, 1'b1, 5'd1);
        drain();

        // Back-to-back with out_ready tied high
        send(8'h00, 1'b1, 8'h01, 1'b1, 5'd1);
        send(8'hFF, 1'b1, 8'h10, 1'b0, 5'd16);
        drain();

        // MAX_ITER=1 instance
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b1;
        bus1.in_data  = 8'h05;
        @(negedge clk);
        check("m1_in_ready", bus1.in_ready, 32'd1);
        acc1 = cyc + 1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus1.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("m1_timeout", 32'd0, 32'd1);
        end else begin
            check("m1_latency", cyc - acc1, 32'd1);
            check("m1_out_data", bus1.out_data, 32'h05);
            check("m1_out_converged", bus1.out_converged, 32'd0);
            check("m1_out_iters", bus1.out_iters, 32'd1);
        end
        @(negedge clk);
        check("m1_back_idle", bus1.in_ready, 32'd1);

        check("sb_empty", sb.size(), 32'd0);
        check("result_count", n_results, 32'd6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dfg_loop_settle.md
Name: dfg_loop_settle

Overview:
- Sequential evaluator for the circular wire network used in the DFG cycle tests (the rings a/b/d and x/y/z/w).
- Each feedback ring is broken by a register. The block then iterates one evaluation step per clock until the logic ring (x, y, z, w) reaches a fixed point, or until an iteration cap is hit.
- It consumes an input sample, reports the settled output o = b | x, a convergence flag and the step count.
- It acts as a golden-model stage downstream of the input driver and upstream of the result checker.

Parameters:
- WIDTH, 8, width of the input sample and of every ring register.
- MAX_ITER, 16, maximum evaluation steps before giving up (must be ≥1).
- CNT_W, $clog2(MAX_ITER+1), width of the step counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample; high only in IDLE.
- in_data  input  WIDTH  sample i.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  o = b | x after the final step.
- out_converged  output  1  1 means the logic ring reached a fixed point; 0 means the cap was hit.
- out_iters  output  CNT_W  number of steps performed (1..MAX_ITER).

Behaviour:
- Reset values: state=IDLE; in_ready=1 in the first cycle after reset; out_valid=0, out_data=0, out_converged=0, out_iters=0. All ring registers and the latched i are cleared.
- Reset has priority over everything. Reset mid-ITER or in DONE discards the work in progress, and no result is emitted.
- States:
  - IDLE: in_ready=1. On in_valid: latch i=in_data, clear a, b, x, y, z, w and the step counter, then go to ITER.
  - ITER: one step per cycle, all registers updated simultaneously from old values. WIDTH-bit arithmetic, wrap modulo 2^WIDTH, carries dropped.
    - d = i + 2
    - a' = b + d; b' = a + 1
    - x' = y ^ i; y' = x
    - w' = y & z; z' = w
    - cnt' = cnt + 1
  - Step evaluation in ITER:
    - If {x', y', z', w'} == {x, y, z, w}: converged. Go to DONE with out_converged=1 and out_iters=cnt+1.
    - Otherwise, if cnt+1 == MAX_ITER: go to DONE with out_converged=0 and out_iters=MAX_ITER.
    - Otherwise stay in ITER.
  - DONE: out_valid=1; out_data = b' | x' from the final step, registered. Outputs stay stable while out_valid=1 and out_ready=0. On out_ready, go to IDLE and drop out_valid.
- The a/b ring never enters the convergence check; it is a free-running accumulator.
- Latency: sample accepted at cycle T, step k performed at the end of cycle T+k. out_valid is first high at cycle T+k+1. Minimum latency is 2 cycles (k=1).
- Throughput: one sample in flight. in_ready=0 in ITER and DONE; in_valid there is ignored and must not corrupt state. in_ready returns the cycle after the out handshake, so back-to-back samples are spaced latency+1 cycles apart.
- out_valid may be high in the same cycle out_ready is already high. The handshake completes in that cycle (zero wait).
- MAX_ITER=1: exactly one step, result emitted regardless of convergence. If that step is stable, out_converged=1.
- No combinational path from in_* to out_*.

Test Plan:
- Reset, then in_data=8'h00 -> out_valid at T+2; out_data=8'h01 (a=2, b=1, x=0); out_converged=1; out_iters=1.
- in_data=8'h01, MAX_ITER=16 -> x/y cycle with period 4, never stable. out_valid at T+17; out_converged=0; out_iters=16; out_data=8'h20 (a=b=32, x=0).
- Hold out_ready=0 for 5 cycles after out_valid -> all out_* stable and in_ready=0. Pulse in_valid during the stall -> ignored; next result is still for the first sample.
- Assert rst two cycles into ITER for in_data=8'h01 -> no out_valid; in_ready=1 in the first cycle after reset. A following in_data=8'h00 yields the same result as the first scenario.
- Back-to-back: 8'h00 then 8'hFF with out_ready tied high -> two results in order. Second sample: out_converged=0, out_iters=16, d=8'h01, out_data = b16 | x16 = 8'h10 | 8'h00 = 8'h10.
- MAX_ITER=1 build, in_data=8'h05 -> out_iters=1, out_converged=0, out_data = 8'h01 | 8'h05 = 8'h05.
